// File: rtl/dmem_pkg.sv
// Shared types and constants for the handshaked data-memory responder.
//   state_e   : responder FSM states (IDLE, WAIT, RESP)
//   LANES     : byte lanes per 32-bit word
//   LANE_W    : bits per byte lane
//   lane_mask : expands a per-lane enable vector into a 32-bit bit mask
package dmem_pkg;

  localparam int LANES  = 4;
  localparam int LANE_W = 8;
  localparam int WORD_W = LANES * LANE_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic [WORD_W-1:0] lane_mask(input logic [LANES-1:0] be);
    logic [WORD_W-1:0] m;
    m = '0;
    for (int i = 0; i < LANES; i++) begin
      m[i*LANE_W +: LANE_W] = {LANE_W{be[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// DEPTH_WORDS x 32-bit storage array with per-byte write enables.
// Ports:
//   clk   : rising-edge clock; writes commit on this edge
//   we    : word write strobe
//   be    : per-lane write enables, qualified by we
//   addr  : word index, shared by read and write
//   wdata : write data, lane i = bits [8i+7:8i]
//   rdata : combinational read of the addressed word
module dmem_bank
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [LANES-1:0]  be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  // NOTE: the array has no reset on purpose; contents survive a reset of
  // the responder and the array maps onto plain RAM without a clear path.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < LANES; i++) begin
        if (be[i]) begin
          mem[addr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Slave end of the core's load/store interface. Accepts one request at a
// time, waits WAIT_STATES cycles, performs a byte-masked store or load and
// holds the response until it is acknowledged.
// Ports:
//   clk, reset         : rising-edge clock, asynchronous active-low reset
//   req_valid/ready    : request handshake (ready only while IDLE)
//   req_write          : 1 = store, 0 = load
//   req_addr           : byte address; word index = req_addr[ADDR_W+1:2]
//   req_wdata          : store data
//   req_byteen         : lane enables for stores and loads
//   rsp_valid/ready    : response handshake
//   rsp_rdata          : load data; zero for stores and errors
//   rsp_err            : address beyond the array
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [LANES-1:0]  req_byteen,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int         ADDR_W    = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [31:2]       addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [LANES-1:0]  be_q, be_d;
  logic [WORD_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic              addr_err;
  logic              bank_we;
  logic [WORD_W-1:0] bank_rdata;

  // Byte offset within a word never influences an access.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^req_addr[1:0];

  // Any address bit above the word index means the access is out of range.
  assign addr_err = |addr_q[31:ADDR_W+2];

  dmem_bank #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (ADDR_W)
  ) u_bank (
    .clk   (clk),
    .we    (bank_we),
    .be    (be_q),
    .addr  (addr_q[ADDR_W+1:2]),
    .wdata (wdata_q),
    .rdata (bank_rdata)
  );

  // NOTE: every signal driven here gets its default first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    bank_we     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          wr_d    = req_write;
          addr_d  = req_addr[31:2];
          wdata_d = req_wdata;
          be_d    = req_byteen;
          cnt_d   = WAIT_INIT;
          state_d = WAIT;
        end
      end

      WAIT: begin
        // The counter holds the wait states still to burn; the access edge
        // is the one after the last wait state, so the response appears
        // WAIT_STATES+1 edges after the accept edge.
        if (cnt_q == 4'd0) begin
          bank_we     = wr_q && !addr_err;
          rsp_err_d   = addr_err;
          rsp_rdata_d = (wr_q || addr_err) ? '0 : (bank_rdata & lane_mask(be_q));
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state is written with non-blocking assignments so all
  // flops sample their _d values from the same point in time.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Handshake outputs are decoded from the state register only.
  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
